op_sequencer: RTL and testbench



---
 rtl/op_seq_pkg.sv | 61 ++++++
 rtl/op_seq_decode.sv | 25 ++
 rtl/op_sequencer.sv | 92 +++++++++
 tb/tb_op_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/op_seq_pkg.sv
// Shared definitions for the op_sequencer: control-bus bit positions, opcodes,
// state encoding and the opcode-to-ALU-bit map.
package op_seq_pkg;

  localparam int CB_LD_A         = 0;
  localparam int CB_LD_B         = 1;
  localparam int CB_LD_O         = 2;
  localparam int CB_SEL_A        = 3;
  localparam int CB_SEL_B        = 4;
  localparam int CB_SH_LOAD      = 5;
  localparam int CB_SH_LEFT      = 6;
  localparam int CB_SH_RIGHT     = 7;
  localparam int CB_MUX2_SH      = 8;
  localparam int CB_ALU_ADD      = 9;
  localparam int CB_ALU_SUB      = 10;
  localparam int CB_ALU_AND      = 11;
  localparam int CB_ALU_OR       = 12;
  localparam int CB_ALU_XOR      = 13;
  localparam int CB_ALU_MUL_STEP = 14;
  localparam int CB_ACC_LOAD     = 15;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;

  // Encodings are visible on state_dbg, so keep them stable.
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_LOAD      = 4'd1,
    ST_OPA       = 4'd2,
    ST_OPB       = 4'd3,
    ST_MUL_INIT  = 4'd4,
    ST_MUL_STEP  = 4'd5,
    ST_MUL_SHIFT = 4'd6,
    ST_STORE     = 4'd7,
    ST_DONE      = 4'd8
  } state_t;

  function automatic logic [15:0] cb(input int idx);
    return 16'(1) << idx;
  endfunction

  // ALU function bit for the second-operand state; MUL and reserved map to none.
  function automatic logic [15:0] alu_bit(input logic [2:0] op);
    logic [15:0] m;
    m = '0;
    case (op)
      OP_ADD:  m = cb(CB_ALU_ADD);
      OP_SUB:  m = cb(CB_ALU_SUB);
      OP_AND:  m = cb(CB_ALU_AND);
      OP_OR:   m = cb(CB_ALU_OR);
      OP_XOR:  m = cb(CB_ALU_XOR);
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/op_seq_decode.sv
// Combinational map from sequencer state and latched opcode to the 16-bit
// datapath control word.
module op_seq_decode
  import op_seq_pkg::*;
(
  input  state_t      state,
  input  logic [2:0]  opcode,
  output logic [15:0] control
);

  always_comb begin
    control = '0;
    case (state)
      ST_LOAD:      control = cb(CB_LD_A) | cb(CB_LD_B) | cb(CB_ACC_LOAD);
      ST_OPA:       control = cb(CB_SEL_A) | cb(CB_ALU_ADD) | cb(CB_ACC_LOAD);
      ST_OPB:       control = cb(CB_SEL_B) | alu_bit(opcode) | cb(CB_ACC_LOAD);
      ST_MUL_INIT:  control = cb(CB_SEL_B) | cb(CB_SH_LOAD);
      ST_MUL_STEP:  control = cb(CB_SEL_A) | cb(CB_ALU_MUL_STEP) | cb(CB_ACC_LOAD);
      ST_MUL_SHIFT: control = cb(CB_SEL_B) | cb(CB_SH_RIGHT);
      ST_STORE:     control = cb(CB_LD_O);
      default:      control = '0;
    endcase
  end

endmodule

// File: rtl/op_sequencer.sv
// Control-word sequencer: walks the datapath through load/compute/store for
// ALU ops and an iterative add/shift loop for MUL. All outputs are Moore.
module op_sequencer
  import op_seq_pkg::*;
#(
  parameter int MUL_ITERS = 4,
  parameter int CNT_W     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  opcode,
  input  logic        flag,
  output logic [15:0] control,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  state_dbg
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITERS - 1);

  state_t            state_q, state_d;
  logic [2:0]        opcode_q, opcode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // flag only matters to the ALU during MUL steps; kept as a hook here.
  logic unused_flag;
  assign unused_flag = flag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      opcode_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          opcode_d = opcode;
          cnt_d    = '0;
          // Reserved opcodes skip the datapath and report through err.
          if (opcode <= OP_MUL) state_d = ST_LOAD;
          else                  state_d = ST_DONE;
        end
      end
      ST_LOAD:     state_d = (opcode_q == OP_MUL) ? ST_MUL_INIT : ST_OPA;
      ST_OPA:      state_d = ST_OPB;
      ST_OPB:      state_d = ST_STORE;
      ST_MUL_INIT: begin
        cnt_d   = '0;
        state_d = ST_MUL_STEP;
      end
      ST_MUL_STEP: state_d = ST_MUL_SHIFT;
      ST_MUL_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_STORE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_MUL_STEP;
        end
      end
      ST_STORE:    state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  op_seq_decode u_decode (
    .state   (state_q),
    .opcode  (opcode_q),
    .control (control)
  );

  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    err       = (state_q == ST_DONE) && (opcode_q[2:1] == 2'b11);
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer: a per-cycle vector table, hand-written MUL
// and reset sequences, then a randomized invariant sweep.
module tb_op_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  opcode;
  logic        flag;
  logic [15:0] control;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  state_dbg;

  int checks;
  int errors;

  op_sequencer #(.MUL_ITERS(4), .CNT_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .opcode    (opcode),
    .flag      (flag),
    .control   (control),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [2:0]  op;
    logic [15:0] ctl;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic [2:0] op, input logic [15:0] ctl,
                              input logic b, input logic d, input logic e, input logic [3:0] st);
    vec_t v;
    v.start = s; v.op = op; v.ctl = ctl; v.busy = b; v.done = d; v.err = e; v.st = st;
    return v;
  endfunction

  task automatic check_out(input string name, input logic [15:0] ctl, input logic b,
                           input logic d, input logic e, input logic [3:0] st);
    checks++;
    if (control !== ctl || busy !== b || done !== d || err !== e || state_dbg !== st) begin
      errors++;
      $display("FAIL %s: got ctl=%h busy=%b done=%b err=%b st=%0d, expected ctl=%h busy=%b done=%b err=%b st=%0d",
               name, control, busy, done, err, state_dbg, ctl, b, d, e, st);
    end
  endtask

  task automatic step(input logic s, input logic [2:0] op);
    @(negedge clk);
    start  = s;
    opcode = op;
    @(posedge clk);
    #1;
  endtask

  // Expected outputs in cycle c after a MUL is accepted.
  task automatic exp_mul(input int c, output logic [15:0] ctl, output logic b,
                         output logic d, output logic [3:0] st);
    b = 1'b1; d = 1'b0;
    if (c == 1)       begin ctl = 16'h8003; st = 4'd1; end
    else if (c == 2)  begin ctl = 16'h0030; st = 4'd4; end
    else if (c <= 10) begin
      if (c % 2 == 1) begin ctl = 16'hC008; st = 4'd5; end
      else            begin ctl = 16'h0090; st = 4'd6; end
    end
    else if (c == 11) begin ctl = 16'h0004; st = 4'd7; end
    else if (c == 12) begin ctl = 16'h0000; st = 4'd8; d = 1'b1; end
    else              begin ctl = 16'h0000; st = 4'd0; b = 1'b0; end
  endtask

  initial begin
    logic [15:0] e_ctl;
    logic        e_b, e_d;
    logic [3:0]  e_st;
    logic        prev_ldo;
    int          ldo_count;
    logic [15:0] add_ctl [0:5];
    logic [3:0]  add_st  [0:5];

    checks = 0; errors = 0;
    reset = 1'b0; start = 1'b0; opcode = 3'd0; flag = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_out("idle_after_reset", 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0);

    // ADD
    vecs.push_back(mk(1, 3'd0, 16'h8003, 1, 0, 0, 4'd1));
    vecs.push_back(mk(0, 3'd0, 16'h8208, 1, 0, 0, 4'd2));
    vecs.push_back(mk(0, 3'd0, 16'h8210, 1, 0, 0, 4'd3));
    vecs.push_back(mk(0, 3'd0, 16'h0004, 1, 0, 0, 4'd7));
    vecs.push_back(mk(0, 3'd0, 16'h0000, 1, 1, 0, 4'd8));
    vecs.push_back(mk(0, 3'd0, 16'h0000, 0, 0, 0, 4'd0));
    // XOR with start held and opcode toggling; back-to-back accept from IDLE
    vecs.push_back(mk(1, 3'd4, 16'h8003, 1, 0, 0, 4'd1));
    vecs.push_back(mk(1, 3'd1, 16'h8208, 1, 0, 0, 4'd2));
    vecs.push_back(mk(1, 3'd1, 16'hA010, 1, 0, 0, 4'd3));
    vecs.push_back(mk(1, 3'd4, 16'h0004, 1, 0, 0, 4'd7));
    vecs.push_back(mk(1, 3'd4, 16'h0000, 1, 1, 0, 4'd8));
    vecs.push_back(mk(1, 3'd4, 16'h0000, 0, 0, 0, 4'd0));
    vecs.push_back(mk(1, 3'd4, 16'h8003, 1, 0, 0, 4'd1));
    vecs.push_back(mk(1, 3'd1, 16'h8208, 1, 0, 0, 4'd2));
    vecs.push_back(mk(1, 3'd1, 16'hA010, 1, 0, 0, 4'd3));
    vecs.push_back(mk(1, 3'd4, 16'h0004, 1, 0, 0, 4'd7));
    vecs.push_back(mk(0, 3'd4, 16'h0000, 1, 1, 0, 4'd8));
    vecs.push_back(mk(0, 3'd4, 16'h0000, 0, 0, 0, 4'd0));
    // Reserved opcodes
    vecs.push_back(mk(1, 3'd7, 16'h0000, 1, 1, 1, 4'd8));
    vecs.push_back(mk(0, 3'd0, 16'h0000, 0, 0, 0, 4'd0));
    vecs.push_back(mk(1, 3'd6, 16'h0000, 1, 1, 1, 4'd8));
    vecs.push_back(mk(0, 3'd0, 16'h0000, 0, 0, 0, 4'd0));
    // SUB, AND, OR second-operand words
    vecs.push_back(mk(1, 3'd1, 16'h8003, 1, 0, 0, 4'd1));
    vecs.push_back(mk(0, 3'd0, 16'h8208, 1, 0, 0, 4'd2));
    vecs.push_back(mk(0, 3'd0, 16'h8410, 1, 0, 0, 4'd3));
    vecs.push_back(mk(0, 3'd0, 16'h0004, 1, 0, 0, 4'd7));
    vecs.push_back(mk(0, 3'd0, 16'h0000, 1, 1, 0, 4'd8));
    vecs.push_back(mk(1, 3'd2, 16'h0000, 0, 0, 0, 4'd0));
    vecs.push_back(mk(1, 3'd2, 16'h8003, 1, 0, 0, 4'd1));
    vecs.push_back(mk(0, 3'd0, 16'h8208, 1, 0, 0, 4'd2));
    vecs.push_back(mk(0, 3'd0, 16'h8810, 1, 0, 0, 4'd3));
    vecs.push_back(mk(0, 3'd0, 16'h0004, 1, 0, 0, 4'd7));
    vecs.push_back(mk(0, 3'd0, 16'h0000, 1, 1, 0, 4'd8));
    vecs.push_back(mk(0, 3'd0, 16'h0000, 0, 0, 0, 4'd0));
    vecs.push_back(mk(1, 3'd3, 16'h8003, 1, 0, 0, 4'd1));
    vecs.push_back(mk(0, 3'd0, 16'h8208, 1, 0, 0, 4'd2));
    vecs.push_back(mk(0, 3'd0, 16'h9010, 1, 0, 0, 4'd3));
    vecs.push_back(mk(0, 3'd0, 16'h0004, 1, 0, 0, 4'd7));
    vecs.push_back(mk(0, 3'd0, 16'h0000, 1, 1, 0, 4'd8));
    vecs.push_back(mk(0, 3'd0, 16'h0000, 0, 0, 0, 4'd0));

    foreach (vecs[i]) begin
      step(vecs[i].start, vecs[i].op);
      check_out($sformatf("vec%0d", i), vecs[i].ctl, vecs[i].busy, vecs[i].done,
                vecs[i].err, vecs[i].st);
      $display("vec %0d start=%b op=%0d ctl=%h done=%b err=%b st=%0d",
               i, vecs[i].start, vecs[i].op, control, done, err, state_dbg);
    end

    // MUL: opcode scrambled after acceptance must not matter
    ldo_count = 0;
    step(1'b1, 3'd5);
    for (int c = 1; c <= 13; c++) begin
      if (c > 1) step(1'b0, 3'($urandom_range(0, 7)));
      exp_mul(c, e_ctl, e_b, e_d, e_st);
      if (control[2]) ldo_count++;
      check_out($sformatf("mul_c%0d", c), e_ctl, e_b, e_d, 1'b0, e_st);
    end
    checks++;
    if (ldo_count != 1) begin
      errors++;
      $display("FAIL mul_ld_o_count: got %0d, expected 1", ldo_count);
    end
    $display("mul run complete, LD_O pulses=%0d", ldo_count);

    // Reset asserted while in MUL_STEP
    step(1'b1, 3'd5);
    step(1'b0, 3'd0);
    step(1'b0, 3'd0);
    check_out("pre_reset_mul_step", 16'hC008, 1'b1, 1'b0, 1'b0, 4'd5);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_out("reset_async", 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0);
    @(posedge clk); #1;
    check_out("reset_next_cycle", 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    reset = 1'b1;
    add_ctl[0] = 16'h8003; add_st[0] = 4'd1;
    add_ctl[1] = 16'h8208; add_st[1] = 4'd2;
    add_ctl[2] = 16'h8210; add_st[2] = 4'd3;
    add_ctl[3] = 16'h0004; add_st[3] = 4'd7;
    add_ctl[4] = 16'h0000; add_st[4] = 4'd8;
    add_ctl[5] = 16'h0000; add_st[5] = 4'd0;
    for (int c = 0; c < 6; c++) begin
      step(c == 0, 3'd0);
      check_out($sformatf("post_reset_add_c%0d", c + 1), add_ctl[c], c < 5, c == 4,
                1'b0, add_st[c]);
    end

    // Random sweep of invariants
    prev_ldo = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      start  = ($urandom_range(0, 3) == 0);
      opcode = 3'($urandom_range(0, 7));
      flag   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      checks++;
      if ((control[3] && control[4]) || ($countones(control[14:9]) > 1) ||
          (err && !done) || (done && !err && !prev_ldo) || (prev_ldo && !done)) begin
        errors++;
        $display("FAIL rand_invariant cycle %0d: got ctl=%h done=%b err=%b prev_ld_o=%b, expected exclusive SEL, one ALU bit, done exactly after LD_O",
                 n, control, done, err, prev_ldo);
      end
      prev_ldo = control[2];
    end
    $display("random sweep complete");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
